// File: rtl/lifo_port_arbiter_if.sv
// Bus between the LIFO port arbiter and its surroundings: the requester side
// (requests, grants, pop responses) plus the LIFO strobes and status.
//   master : the environment (client logic and the LIFO itself)
//   slave  : the arbiter
// Ports:
//   req_push/req_pop/req_data  requests, held until granted
//   grant, rsp_valid, rsp_data accept strobe and pop response per requester
//   lifo_write/lifo_read/lifo_data_in/lifo_data_out  LIFO access
//   count/full/empty           tracked occupancy
interface lifo_port_arbiter_if #(
   parameter int NUM_REQ   = 2,
   parameter int DATA_W    = 8,
   parameter int LIFO_SIZE = 8
);
   localparam int CNT_W = $clog2(LIFO_SIZE + 1);

   logic [NUM_REQ-1:0]        req_push;
   logic [NUM_REQ-1:0]        req_pop;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      lifo_write;
   logic                      lifo_read;
   logic [DATA_W-1:0]         lifo_data_in;
   logic [DATA_W-1:0]         lifo_data_out;
   logic [CNT_W-1:0]          count;
   logic                      full;
   logic                      empty;

   modport master (
      output req_push, req_pop, req_data, lifo_data_out,
      input  grant, rsp_valid, rsp_data, lifo_write, lifo_read, lifo_data_in,
             count, full, empty
   );

   modport slave (
      input  req_push, req_pop, req_data, lifo_data_out,
      output grant, rsp_valid, rsp_data, lifo_write, lifo_read, lifo_data_in,
             count, full, empty
   );
endinterface

// File: rtl/lifo_port_arbiter.sv
// Shares one LIFO between NUM_REQ requesters. Each cycle a round-robin search
// picks at most one push or pop, drives the LIFO strobes, tracks occupancy so
// blocked operations never issue, and returns pop data to the popping
// requester one cycle after its grant.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    lifo_port_arbiter_if.slave (requests, grants, responses, LIFO side)
module lifo_port_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int DATA_W    = 8,
   parameter int LIFO_SIZE = 8
) (
   input logic                 clk,
   input logic                 reset,
   lifo_port_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(LIFO_SIZE + 1);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LIFO_SIZE);

   logic [CNT_W-1:0]   count_q;
   logic [PTR_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] rsp_vld_q;
   logic               full, empty;
   logic [NUM_REQ-1:0] push_ok, pop_ok;
   logic               gnt_vld, gnt_push;
   logic [PTR_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] grant;
   logic               lifo_write, lifo_read;
   logic [DATA_W-1:0]  lifo_data_in;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // Per-requester eligibility: a pushable push shadows a pop on the same lane.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      assign push_ok[i] = bus.req_push[i] & ~full;
      assign pop_ok[i]  = bus.req_pop[i] & ~empty & ~push_ok[i];
   end

   // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      int idx;
      gnt_vld  = 1'b0;
      gnt_push = 1'b0;
      gnt_idx  = '0;
      idx      = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(rr_ptr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_vld && (push_ok[idx] || pop_ok[idx])) begin
            gnt_vld  = 1'b1;
            gnt_idx  = PTR_W'(idx);
            gnt_push = push_ok[idx];
         end
      end
      if (reset) gnt_vld = 1'b0;
   end

   always_comb begin
      grant = '0;
      if (gnt_vld) grant[gnt_idx] = 1'b1;
      lifo_write   = gnt_vld & gnt_push;
      lifo_read    = gnt_vld & ~gnt_push;
      lifo_data_in = lifo_write ? bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         rr_ptr    <= '0;
         rsp_vld_q <= '0;
      end else begin
         rsp_vld_q <= lifo_read ? grant : '0;
         if (lifo_write)     count_q <= count_q + 1'b1;
         else if (lifo_read) count_q <= count_q - 1'b1;
         if (gnt_vld) rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   assign bus.grant        = grant;
   assign bus.lifo_write   = lifo_write;
   assign bus.lifo_read    = lifo_read;
   assign bus.lifo_data_in = lifo_data_in;
   // Masking with reset drops a response whose pop was granted just before
   // reset rose, instead of letting it show during the reset cycle.
   assign bus.rsp_valid    = rsp_vld_q & {NUM_REQ{~reset}};
   assign bus.rsp_data     = bus.lifo_data_out;
   assign bus.count        = count_q;
   assign bus.full         = full;
   assign bus.empty        = empty;

   // Requester protocol: a pending op stays asserted (push data stable) until
   // that op is granted; reset releases all requests.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_proto
      a_push_hold: assert property (@(posedge clk)
         (!reset && bus.req_push[i] && !(grant[i] && lifo_write)) |=>
         (reset || (bus.req_push[i] && $stable(bus.req_data[i*DATA_W +: DATA_W]))));
      a_pop_hold: assert property (@(posedge clk)
         (!reset && bus.req_pop[i] && !(grant[i] && lifo_read)) |=>
         (reset || bus.req_pop[i]));
   end

   a_one_op: assert property (@(posedge clk) !(lifo_write && lifo_read));
endmodule

// File: tb/tb_lifo_port_arbiter.sv
// Bench for lifo_port_arbiter (NUM_REQ=2, DATA_W=8, LIFO_SIZE=4): a directed
// vector table, a hand-written reset-during-pop sequence, then randomized
// requests checked against a queue-based reference model.
module tb_lifo_port_arbiter;
   localparam int NR = 2;
   localparam int DW = 8;
   localparam int LS = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   lifo_port_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .LIFO_SIZE(LS)) bus ();
   lifo_port_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LIFO_SIZE(LS)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // Behavioural stand-in for the shared LIFO, cleared by the same reset.
   logic [DW-1:0] mem [LS];
   int sp;
   always @(posedge clk) begin
      if (reset) begin
         sp <= 0;
         bus.lifo_data_out <= '0;
      end else if (bus.lifo_write && sp < LS) begin
         mem[sp] <= bus.lifo_data_in;
         sp <= sp + 1;
      end else if (bus.lifo_read && sp > 0) begin
         bus.lifo_data_out <= mem[sp-1];
         sp <= sp - 1;
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [1:0] push, input logic [1:0] pop,
                        input logic [7:0] d0, input logic [7:0] d1);
      reset = rst;
      bus.req_push = push;
      bus.req_pop = pop;
      bus.req_data = {d1, d0};
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] push, pop;
      logic [7:0] d0, d1;
      logic [1:0] grant;
      logic       wr, rd;
      logic [7:0] din;
      logic [1:0] rspv;
      logic [7:0] rspd;
      int         cnt;
   } vec_t;

   function automatic vec_t row(input logic rst, input logic [1:0] push, input logic [1:0] pop,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [1:0] g, input logic wr, input logic rd,
                                input logic [7:0] din, input logic [1:0] rv,
                                input logic [7:0] rdat, input int cnt);
      vec_t v;
      v.rst = rst; v.push = push; v.pop = pop; v.d0 = d0; v.d1 = d1;
      v.grant = g; v.wr = wr; v.rd = rd; v.din = din; v.rspv = rv; v.rspd = rdat; v.cnt = cnt;
      return v;
   endfunction

   vec_t tbl[$];

   // Reference model state: occupancy and contents as a plain queue.
   logic [7:0] m_stack[$];
   int         m_rr = 0;
   logic [1:0] m_rsp = '0;
   logic [7:0] m_rsp_data = '0;
   bit         pend_push[NR];
   bit         pend_pop[NR];
   logic [7:0] pdata[NR];

   task automatic model_cycle(input logic rst);
      logic [1:0] eg = '0;
      logic [7:0] edin = '0;
      int g = -1;
      bit gp = 1'b0;
      if (!rst) begin
         for (int k = 0; k < NR; k++) begin
            int i;
            bit can_push, can_pop;
            i = (m_rr + k) % NR;
            can_push = pend_push[i] && (m_stack.size() < LS);
            can_pop  = pend_pop[i] && (m_stack.size() > 0);
            if (g < 0 && (can_push || can_pop)) begin
               g = i;
               gp = can_push;
            end
         end
      end
      if (g >= 0) begin
         eg[g] = 1'b1;
         if (gp) edin = pdata[g];
      end
      check("rnd_grant", bus.grant, eg);
      check("rnd_write", bus.lifo_write, (g >= 0) && gp);
      check("rnd_read", bus.lifo_read, (g >= 0) && !gp);
      check("rnd_data_in", bus.lifo_data_in, edin);
      check("rnd_rsp_valid", bus.rsp_valid, rst ? 2'b00 : m_rsp);
      if (!rst && m_rsp != 2'b00) check("rnd_rsp_data", bus.rsp_data, m_rsp_data);
      check("rnd_count", bus.count, m_stack.size());
      check("rnd_full", bus.full, m_stack.size() == LS);
      check("rnd_empty", bus.empty, m_stack.size() == 0);
      if (rst) begin
         m_stack.delete();
         m_rr = 0;
         m_rsp = '0;
      end else begin
         m_rsp = '0;
         if (g >= 0) begin
            if (gp) begin
               m_stack.push_back(pdata[g]);
               pend_push[g] = 1'b0;
            end else begin
               m_rsp_data = m_stack.pop_back();
               m_rsp[g] = 1'b1;
               pend_pop[g] = 1'b0;
            end
            m_rr = (g + 1) % NR;
         end
      end
   endtask

   initial begin
      drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00);

      // Reset, fill to full, two-requester pushes, pops to empty, push/pop mix.
      tbl.push_back(row(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 0));
      tbl.push_back(row(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 0));
      tbl.push_back(row(1'b0, 2'b01, 2'b00, 8'h11, 8'h00, 2'b01, 1'b1, 1'b0, 8'h11, 2'b00, 8'h00, 0));
      tbl.push_back(row(1'b0, 2'b01, 2'b00, 8'h22, 8'h00, 2'b01, 1'b1, 1'b0, 8'h22, 2'b00, 8'h00, 1));
      tbl.push_back(row(1'b0, 2'b01, 2'b00, 8'h33, 8'h00, 2'b01, 1'b1, 1'b0, 8'h33, 2'b00, 8'h00, 2));
      tbl.push_back(row(1'b0, 2'b01, 2'b00, 8'h44, 8'h00, 2'b01, 1'b1, 1'b0, 8'h44, 2'b00, 8'h00, 3));
      tbl.push_back(row(1'b0, 2'b01, 2'b00, 8'h55, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 4));
      tbl.push_back(row(1'b0, 2'b01, 2'b00, 8'h55, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 4));
      tbl.push_back(row(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 4));
      tbl.push_back(row(1'b0, 2'b11, 2'b00, 8'hA0, 8'hB1, 2'b01, 1'b1, 1'b0, 8'hA0, 2'b00, 8'h00, 0));
      tbl.push_back(row(1'b0, 2'b10, 2'b00, 8'h00, 8'hB1, 2'b10, 1'b1, 1'b0, 8'hB1, 2'b00, 8'h00, 1));
      tbl.push_back(row(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 8'h00, 2'b00, 8'h00, 2));
      tbl.push_back(row(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 8'hB1, 1));
      tbl.push_back(row(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 1));
      tbl.push_back(row(1'b0, 2'b01, 2'b00, 8'h11, 8'h00, 2'b01, 1'b1, 1'b0, 8'h11, 2'b00, 8'h00, 0));
      tbl.push_back(row(1'b0, 2'b01, 2'b00, 8'h22, 8'h00, 2'b01, 1'b1, 1'b0, 8'h22, 2'b00, 8'h00, 1));
      tbl.push_back(row(1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 2'b00, 8'h00, 2));
      tbl.push_back(row(1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 2'b10, 8'h22, 1));
      tbl.push_back(row(1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 8'h11, 0));
      tbl.push_back(row(1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 0));
      tbl.push_back(row(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 0));
      tbl.push_back(row(1'b0, 2'b10, 2'b00, 8'h00, 8'h77, 2'b10, 1'b1, 1'b0, 8'h77, 2'b00, 8'h00, 0));
      tbl.push_back(row(1'b0, 2'b01, 2'b10, 8'h55, 8'h00, 2'b01, 1'b1, 1'b0, 8'h55, 2'b00, 8'h00, 1));
      tbl.push_back(row(1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 8'h00, 2'b00, 8'h00, 2));
      tbl.push_back(row(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 8'h55, 1));

      @(posedge clk); #1;
      foreach (tbl[r]) begin
         drive(tbl[r].rst, tbl[r].push, tbl[r].pop, tbl[r].d0, tbl[r].d1);
         @(negedge clk);
         check($sformatf("v%0d_grant", r), bus.grant, tbl[r].grant);
         check($sformatf("v%0d_write", r), bus.lifo_write, tbl[r].wr);
         check($sformatf("v%0d_read", r), bus.lifo_read, tbl[r].rd);
         check($sformatf("v%0d_data_in", r), bus.lifo_data_in, tbl[r].din);
         check($sformatf("v%0d_rsp_valid", r), bus.rsp_valid, tbl[r].rspv);
         if (tbl[r].rspv != 2'b00) check($sformatf("v%0d_rsp_data", r), bus.rsp_data, tbl[r].rspd);
         check($sformatf("v%0d_count", r), bus.count, tbl[r].cnt);
         check($sformatf("v%0d_full", r), bus.full, tbl[r].cnt == LS);
         check($sformatf("v%0d_empty", r), bus.empty, tbl[r].cnt == 0);
         @(posedge clk); #1;
      end

      // Pop granted, then reset in the very next cycle: response must vanish.
      drive(1'b0, 2'b00, 2'b10, 8'h00, 8'h00);
      @(negedge clk);
      check("rst_pop_grant", bus.grant, 2'b10);
      check("rst_pop_read", bus.lifo_read, 1'b1);
      @(posedge clk); #1;
      drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00);
      @(negedge clk);
      check("rst_pop_rsp_in_reset", bus.rsp_valid, 2'b00);
      check("rst_pop_grant_in_reset", bus.grant, 2'b00);
      @(posedge clk); #1;
      drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00);
      @(negedge clk);
      check("rst_pop_rsp_after", bus.rsp_valid, 2'b00);
      check("rst_pop_count", bus.count, 0);
      check("rst_pop_empty", bus.empty, 1'b1);
      @(posedge clk); #1;

      // Randomized phase against the reference model.
      m_stack.delete();
      m_rr = 0;
      m_rsp = '0;
      for (int i = 0; i < NR; i++) begin
         pend_push[i] = 1'b0;
         pend_pop[i] = 1'b0;
         pdata[i] = '0;
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic rst;
         logic [1:0] pv, qv;
         rst = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < NR; i++) begin
            if (rst) begin
               pend_push[i] = 1'b0;
               pend_pop[i] = 1'b0;
            end else begin
               if (!pend_push[i] && $urandom_range(0, 2) == 0) begin
                  pend_push[i] = 1'b1;
                  pdata[i] = 8'($urandom);
               end
               if (!pend_pop[i] && $urandom_range(0, 2) == 0) pend_pop[i] = 1'b1;
            end
            pv[i] = pend_push[i];
            qv[i] = pend_pop[i];
         end
         drive(rst, pv, qv, pdata[0], pdata[1]);
         @(negedge clk);
         model_cycle(rst);
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
